// File: rtl/aes_pkg.sv
// Shared AES decryption types and the FIPS-197 inverse S-box table.
package aes_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned SEL_W   = 2;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [STATE_W-1:0] state_t;
    typedef logic [ROUND_W-1:0] round_t;

    localparam logic [BYTE_W-1:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Column 0 is the most significant word of the round key.
    function automatic word_t key_word(input state_t key, input logic [SEL_W-1:0] sel);
        word_t kw;
        case (sel)
            2'd0:    kw = key[127:96];
            2'd1:    kw = key[95:64];
            2'd2:    kw = key[63:32];
            default: kw = key[31:0];
        endcase
        return kw;
    endfunction

endpackage

// File: rtl/inv_sbox_byte.sv
// Single-byte inverse S-box lookup.
module inv_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] byte_val,
    output logic [7:0] sub_c
);

    assign sub_c = INV_SBOX[byte_val];

endmodule

// File: rtl/aes_inv_col_stage.sv
// One AES-128 decryption column: InvSubBytes + AddRoundKey, with registered capture
// and the column-step / key-expansion strobe dividers in the clk domain.
module aes_inv_col_stage
    import aes_pkg::*;
#(
    parameter int unsigned DIV_MAIN = 4,
    parameter int unsigned DIV_KEY  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   round,
    input  logic [1:0]   col_sel,
    input  logic [31:0]  col_in,
    input  logic [127:0] round_key,
    output logic [31:0]  col_comb,
    output logic [31:0]  col_q,
    output logic         col_vld,
    output logic         tick_main,
    output logic         tick_key
);

    localparam int unsigned MAIN_W = (DIV_MAIN > 1) ? $clog2(DIV_MAIN) : 1;
    localparam int unsigned KEY_W  = (DIV_KEY > 1) ? $clog2(DIV_KEY) : 1;
    localparam int unsigned NBYTES = WORD_W / BYTE_W;

    localparam logic [MAIN_W-1:0] MAIN_LAST = MAIN_W'(DIV_MAIN - 1);
    localparam logic [KEY_W-1:0]  KEY_LAST  = KEY_W'(DIV_KEY - 1);

    word_t sbox_out;
    word_t sub;
    word_t kw;

    logic [MAIN_W-1:0] main_cnt;
    logic [MAIN_W-1:0] main_cnt_nxt;
    logic [KEY_W-1:0]  key_cnt;
    logic [KEY_W-1:0]  key_cnt_nxt;

    for (genvar g = 0; g < NBYTES; g++) begin : g_sbox
        inv_sbox_byte u_sbox (
            .byte_val (col_in[BYTE_W*g +: BYTE_W]),
            .sub_c    (sbox_out[BYTE_W*g +: BYTE_W])
        );
    end

    // Round 0 is the initial AddRoundKey only, so substitution is bypassed.
    always_comb begin
        sub      = (round == ROUND_W'(0)) ? col_in : sbox_out;
        kw       = key_word(round_key, col_sel);
        col_comb = sub ^ kw;
    end

    always_comb begin
        main_cnt_nxt = (main_cnt == MAIN_LAST) ? '0 : main_cnt + MAIN_W'(1);
        key_cnt_nxt  = (key_cnt == KEY_LAST) ? '0 : key_cnt + KEY_W'(1);
    end

    // Ticks are registered decodes of the next count, so they are high exactly while the count sits at DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_cnt  <= '0;
            key_cnt   <= '0;
            tick_main <= 1'b0;
            tick_key  <= 1'b0;
        end else begin
            main_cnt  <= main_cnt_nxt;
            key_cnt   <= key_cnt_nxt;
            tick_main <= (main_cnt_nxt == MAIN_LAST);
            tick_key  <= (key_cnt_nxt == KEY_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            col_vld <= 1'b0;
        end else if (tick_main) begin
            col_q   <= col_comb;
            col_vld <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_inv_col_stage.sv
// Scoreboard bench for aes_inv_col_stage; reference S-box is derived from GF(2^8) arithmetic.
module tb_aes_inv_col_stage;

    localparam int unsigned DIV_MAIN = 4;
    localparam int unsigned DIV_KEY  = 2;

    logic         clk;
    logic         rst_n;
    logic [3:0]   round;
    logic [1:0]   col_sel;
    logic [31:0]  col_in;
    logic [127:0] round_key;
    logic [31:0]  col_comb;
    logic [31:0]  col_q;
    logic         col_vld;
    logic         tick_main;
    logic         tick_key;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  inv_tbl [256];
    logic [31:0] q_comb [$];
    logic [31:0] q_cap  [$];
    logic [31:0] exp_q;
    logic        exp_vld;

    aes_inv_col_stage #(
        .DIV_MAIN (DIV_MAIN),
        .DIV_KEY  (DIV_KEY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .round     (round),
        .col_sel   (col_sel),
        .col_in    (col_in),
        .round_key (round_key),
        .col_comb  (col_comb),
        .col_q     (col_q),
        .col_vld   (col_vld),
        .tick_main (tick_main),
        .tick_key  (tick_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? (8'(aa << 1) ^ 8'h1b) : 8'(aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] model(input logic [3:0] r, input logic [1:0] s,
                                          input logic [31:0] c, input logic [127:0] k);
        logic [31:0] sub;
        logic [31:0] kw;
        sub = c;
        if (r != 4'd0)
            for (int i = 0; i < 4; i++) sub[8*i +: 8] = inv_tbl[c[8*i +: 8]];
        case (s)
            2'd0:    kw = k[127:96];
            2'd1:    kw = k[95:64];
            2'd2:    kw = k[63:32];
            default: kw = k[31:0];
        endcase
        return sub ^ kw;
    endfunction

    // Drive one column, queue its expected result and score col_comb after settling.
    task automatic drive(input string tag, input logic [3:0] r, input logic [1:0] s,
                         input logic [31:0] c, input logic [127:0] k, output logic [31:0] e);
        round     = r;
        col_sel   = s;
        col_in    = c;
        round_key = k;
        e = model(r, s, c, k);
        q_comb.push_back(e);
        #1;
        chk(tag, col_comb, q_comb.pop_front());
    endtask

    task automatic drive_rand(input string tag, output logic [31:0] e);
        drive(tag, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom,
              {$urandom, $urandom, $urandom, $urandom}, e);
    endtask

    // Called at the negedge where rst_n was just released; cycle c has the counters at c-1.
    task automatic run_ticks(input int n);
        logic [31:0] e;
        int c;
        #1;
        chk("tick_main_c1", 32'(tick_main), 32'(0));
        chk("tick_key_c1", 32'(tick_key), 32'(0));
        drive_rand("comb_run", e);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            c = k + 1;
            if (q_cap.size() > 0) begin
                exp_q   = q_cap.pop_front();
                exp_vld = 1'b1;
            end
            chk("col_q", col_q, exp_q);
            chk("col_vld", 32'(col_vld), 32'(exp_vld));
            chk("tick_main", 32'(tick_main), 32'((c % DIV_MAIN) == 0));
            chk("tick_key", 32'(tick_key), 32'((c % DIV_KEY) == 0));
            drive_rand("comb_run", e);
            if ((c % DIV_MAIN) == 0) q_cap.push_back(e);
        end
        chk("cap_drain", 32'(q_cap.size()), 32'(0));
    endtask

    initial begin
        logic [31:0]  e;
        logic [127:0] kv;
        logic [7:0]   b;
        rst_n     = 1'b0;
        round     = '0;
        col_sel   = '0;
        col_in    = '0;
        round_key = '0;
        exp_q     = '0;
        exp_vld   = 1'b0;
        for (int x = 0; x < 256; x++) inv_tbl[fwd_sbox(8'(x))] = 8'(x);

        repeat (3) @(negedge clk);
        chk("rst_col_q", col_q, 32'h0);
        chk("rst_col_vld", 32'(col_vld), 32'(0));
        chk("rst_tick_main", 32'(tick_main), 32'(0));
        chk("rst_tick_key", 32'(tick_key), 32'(0));

        // Combinational checks held in reset, so col_q must never move.
        drive("fips_r0", 4'd0, 2'd0, 32'h69c4e0d8, 128'h13111d7fe3944a17f307a78b4d2b30c5, e);
        chk("fips_r0_const", e, 32'h7ad5fda7);
        drive("fips_r1", 4'd1, 2'd0, 32'h7a9f1027, 128'h549932d1f08557681093ed9cbe2c974e, e);
        chk("fips_r1_const", e, 32'he9f74eec);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            drive("spot_0063", 4'd1, 2'(s), 32'h00637c53, 128'h0, e);
            chk("spot_0063_const", col_comb, 32'h52000150);
            drive("spot_ffff", 4'd1, 2'(s), 32'hffffffff, 128'h0, e);
            chk("spot_ffff_const", col_comb, 32'h7d7d7d7d);
        end
        kv = 128'h00112233_44556677_8899aabb_ccddeeff;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            drive("key_sel", 4'd0, 2'(s), 32'h0, kv, e);
        end
        for (int x = 0; x < 256; x++) begin
            @(negedge clk);
            b = 8'(x);
            drive("sbox_sweep", 4'(1 + (x % 15)), 2'(x % 4),
                  {b, 8'(b + 8'd1), 8'(b + 8'd85), 8'(b + 8'd170)}, 128'h0, e);
        end
        chk("hold_col_q", col_q, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(13);

        // Asynchronous reset between edges must clear everything immediately.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_col_q", col_q, 32'h0);
        chk("arst_col_vld", 32'(col_vld), 32'(0));
        chk("arst_tick_main", 32'(tick_main), 32'(0));
        chk("arst_tick_key", 32'(tick_key), 32'(0));
        exp_q   = '0;
        exp_vld = 1'b0;
        q_cap.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_ticks(13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_inv_col_stage.md
Name: aes_inv_col_stage

Overview:
- One 32-bit column of an AES-128 decryption round: InvSubBytes on 4 bytes, then AddRoundKey with the key word for the selected column.
- Also generates the two slow-rate timing strobes used by the round sequencer and key expander, as enables in the single clk domain (no derived clocks).
- Sits between inverse ShiftRows (upstream) and inverse MixColumns (downstream).

Parameters:
- DIV_MAIN, 4, clk cycles per tick_main (column-step strobe); legal range 2..256.
- DIV_KEY, 2, clk cycles per tick_key (key-expansion strobe); legal range 2..256.

Ports:
- clk        in   1    system clock
- rst_n      in   1    asynchronous active-low reset
- round      in   4    decryption round index; 0 = initial AddRoundKey only
- col_sel    in   2    column index within the state (0 = bits 127:96)
- col_in     in   32   input column, byte 31:24 = row 0
- round_key  in   128  current round key
- col_comb   out  32   combinational result column
- col_q      out  32   registered result column
- col_vld    out  1    col_q holds a captured result
- tick_main  out  1    one-cycle strobe every DIV_MAIN clk cycles
- tick_key   out  1    one-cycle strobe every DIV_KEY clk cycles

Behaviour:
- Reset values: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0: col_q=0, col_vld=0, tick_main=0, tick_key=0, both divider counters=0.
- Substitution stage (combinational):
  - round==0: sub = col_in (bypass).
  - round!=0, any value 1..15: each byte of col_in passes through the FIPS-197 inverse S-box independently.
- Key select: kw = round_key[127:96], [95:64], [63:32] or [31:0] for col_sel 0, 1, 2, 3 respectively.
- col_comb = sub XOR kw. Purely combinational, zero latency. No X propagation for any input value.
- Capture register:
  - On a rising clk edge with tick_main=1: col_q <= col_comb, col_vld <= 1.
  - Otherwise col_q and col_vld hold.
  - col_vld stays 1 until the next reset.
- Dividers:
  - Each divider is a free-running counter 0..DIV-1.
  - The tick is high for exactly the clk cycle in which the counter equals DIV-1; the counter then wraps to 0.
  - First tick_main is high in the DIV_MAIN-th cycle after reset release; first tick_key is high in the DIV_KEY-th cycle.
  - The two counters are independent and may tick in the same cycle.
- Reset mid-operation: async clear of all state; counters restart from 0.
- Input changes while tick_main=0 affect col_comb only, never col_q.

Decomposition:
- Shared package aes_pkg: 256-entry inverse S-box constant table, plus typedefs for word_t (32b), state_t (128b) and round_t (4b).
- Sub-module inv_sbox_byte (8b in, 8b out, table lookup), instantiated 4 times.
- Dividers stay inline.

Test Plan:
- Round 0, FIPS-197 vector: round=0, col_sel=0, col_in=69c4e0d8, round_key=13111d7fe3944a17f307a78b4d2b30c5 -> col_comb=7ad5fda7.
- Round 1, FIPS-197 vector: round=1, col_sel=0, col_in=7a9f1027, round_key=549932d1f08557681093ed9cbe2c974e -> col_comb=e9f74eec.
- Inverse S-box spot checks: round=1, round_key=0, col_sel swept 0..3.
  - col_in=00637c53 -> 52000150.
  - col_in=ffffffff -> 7d7d7d7d.
  - Exhaustive 256-byte sweep against the table.
- Key word select: round=0, col_in=0, round_key=00112233_44556677_8899aabb_ccddeeff.
  - col_sel 0..3 -> 00112233, 44556677, 8899aabb, ccddeeff.
- Dividers and capture, defaults DIV_MAIN=4, DIV_KEY=2:
  - Release reset, count cycles: tick_main high in cycles 4, 8, 12; tick_key high in 2, 4, 6.
  - col_q updates only after tick_main edges; col_vld rises after the first tick_main.
- Async reset mid-run:
  - Assert rst_n=0 between clk edges -> col_q=0, col_vld=0, ticks=0 immediately.
  - After release, first tick_main occurs 4 cycles later.
